fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding + load-use hazard unit for the 5+ stage MIPS pipeline. Keeps an

---
 rtl/fwd_hazard_unit_if.sv | 33 +++
 rtl/fwd_hazard_unit.sv | 139 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage hazard bus between decode and the forwarding/hazard unit.
// The master drives the decoded ID fields and receives the stall and forward selects.
interface fwd_hazard_unit_if #(
  parameter int REG_AW         = 5,
  parameter int NUM_FWD_STAGES = 2
);
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

  logic              ID_valid;
  logic [REG_AW-1:0] ID_rs;
  logic [REG_AW-1:0] ID_rt;
  logic              ID_uses_rs;
  logic              ID_uses_rt;
  logic [REG_AW-1:0] ID_rDest;
  logic              ID_writes;
  logic              ID_is_load;
  logic              Flush;
  logic              Stall;
  logic [SEL_W-1:0]  EX_fwdA;
  logic [SEL_W-1:0]  EX_fwdB;

  modport master (
    output ID_valid, ID_rs, ID_rt, ID_uses_rs, ID_uses_rt,
    output ID_rDest, ID_writes, ID_is_load, Flush,
    input  Stall, EX_fwdA, EX_fwdB
  );

  modport slave (
    input  ID_valid, ID_rs, ID_rt, ID_uses_rs, ID_uses_rt,
    input  ID_rDest, ID_writes, ID_is_load, Flush,
    output Stall, EX_fwdA, EX_fwdB
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit tracking in-flight destinations in a shadow pipe.
// Optional feature macro STALL_CNT_EN adds a saturating 32-bit stall-cycle counter.
module fwd_hazard_unit #(
  parameter int REG_AW         = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LAT       = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  fwd_hazard_unit_if.slave    bus
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]         Stall_count
`endif
);
  localparam int N     = NUM_FWD_STAGES;
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

  logic [N-1:0]      valid_q, valid_d;
  logic [N-1:0]      wr_q, wr_d;
  logic [N-1:0]      load_q, load_d;
  logic [REG_AW-1:0] dest_q [N];
  logic [REG_AW-1:0] dest_d [N];
  logic [SEL_W-1:0]  fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0]  fwd_b_q, fwd_b_d;

  logic [N-1:0]      match_a_s, match_b_s;
  logic [SEL_W-1:0]  sel_a_s, sel_b_s;
  logic              luse_a_s, luse_b_s;
  logic              stall_s, insert_s;

  // Per-stage destination matches; register 0 and unused sources never match.
  always_comb begin
    match_a_s = {N{1'b0}};
    match_b_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      match_a_s[i] = valid_q[i] && wr_q[i] && (dest_q[i] == bus.ID_rs)
                     && (bus.ID_rs != {REG_AW{1'b0}}) && bus.ID_uses_rs;
      match_b_s[i] = valid_q[i] && wr_q[i] && (dest_q[i] == bus.ID_rt)
                     && (bus.ID_rt != {REG_AW{1'b0}}) && bus.ID_uses_rt;
    end
  end

  // Youngest match wins: scan oldest to youngest so the lowest index overwrites last.
  always_comb begin
    sel_a_s  = {SEL_W{1'b0}};
    sel_b_s  = {SEL_W{1'b0}};
    luse_a_s = 1'b0;
    luse_b_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (match_a_s[i]) begin
        sel_a_s  = SEL_W'(i + 1);
        luse_a_s = load_q[i] && ((i + 1) <= LOAD_LAT);
      end else begin
        sel_a_s  = sel_a_s;
        luse_a_s = luse_a_s;
      end
      if (match_b_s[i]) begin
        sel_b_s  = SEL_W'(i + 1);
        luse_b_s = load_q[i] && ((i + 1) <= LOAD_LAT);
      end else begin
        sel_b_s  = sel_b_s;
        luse_b_s = luse_b_s;
      end
    end
  end

  // Flush overrides stall; reset holds stall low.
  always_comb begin
    stall_s  = bus.ID_valid && (luse_a_s || luse_b_s) && !bus.Flush && !Reset;
    insert_s = bus.ID_valid && !stall_s && !bus.Flush;
  end

  // Shadow pipe shift with ID entry or bubble at the bottom.
  always_comb begin
    valid_d    = {N{1'b0}};
    wr_d       = {N{1'b0}};
    load_d     = {N{1'b0}};
    valid_d[0] = insert_s;
    wr_d[0]    = bus.ID_writes;
    load_d[0]  = bus.ID_is_load;
    dest_d[0]  = bus.ID_rDest;
    for (int i = 1; i < N; i++) begin
      valid_d[i] = valid_q[i-1];
      wr_d[i]    = wr_q[i-1];
      load_d[i]  = load_q[i-1];
      dest_d[i]  = dest_q[i-1];
    end
    fwd_a_d = insert_s ? sel_a_s : {SEL_W{1'b0}};
    fwd_b_d = insert_s ? sel_b_s : {SEL_W{1'b0}};
  end

  // Shadow pipe and forward-select registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= {N{1'b0}};
      wr_q    <= {N{1'b0}};
      load_q  <= {N{1'b0}};
      fwd_a_q <= {SEL_W{1'b0}};
      fwd_b_q <= {SEL_W{1'b0}};
      for (int i = 0; i < N; i++) begin
        dest_q[i] <= {REG_AW{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      load_q  <= load_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      for (int i = 0; i < N; i++) begin
        dest_q[i] <= dest_d[i];
      end
    end
  end

  assign bus.Stall   = stall_s;
  assign bus.EX_fwdA = fwd_a_q;
  assign bus.EX_fwdB = fwd_b_q;

`ifdef STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Saturating stall-cycle count.
  always_comb begin
    cnt_d = (stall_s && (cnt_q != 32'hFFFF_FFFF)) ? (cnt_q + 32'd1) : cnt_q;
  end

  // Stall counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Stall_count = cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default build (N=2, LOAD_LAT=1) and an N=3, LOAD_LAT=2 build.
module tb_fwd_hazard_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic       id_valid, id_uses_rs, id_uses_rt, id_writes, id_is_load, flush;
  logic [4:0] id_rs, id_rt, id_rdest;

  fwd_hazard_unit_if #(.REG_AW(5), .NUM_FWD_STAGES(2)) bus_a ();
  fwd_hazard_unit_if #(.REG_AW(5), .NUM_FWD_STAGES(3)) bus_b ();

  assign bus_a.ID_valid   = id_valid;
  assign bus_a.ID_rs      = id_rs;
  assign bus_a.ID_rt      = id_rt;
  assign bus_a.ID_uses_rs = id_uses_rs;
  assign bus_a.ID_uses_rt = id_uses_rt;
  assign bus_a.ID_rDest   = id_rdest;
  assign bus_a.ID_writes  = id_writes;
  assign bus_a.ID_is_load = id_is_load;
  assign bus_a.Flush      = flush;
  assign bus_b.ID_valid   = id_valid;
  assign bus_b.ID_rs      = id_rs;
  assign bus_b.ID_rt      = id_rt;
  assign bus_b.ID_uses_rs = id_uses_rs;
  assign bus_b.ID_uses_rt = id_uses_rt;
  assign bus_b.ID_rDest   = id_rdest;
  assign bus_b.ID_writes  = id_writes;
  assign bus_b.ID_is_load = id_is_load;
  assign bus_b.Flush      = flush;

`ifdef STALL_CNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  fwd_hazard_unit #(.REG_AW(5), .NUM_FWD_STAGES(2), .LOAD_LAT(1)) dut_a (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus_a)
`ifdef STALL_CNT_EN
    ,
    .Stall_count (cnt_a)
`endif
  );

  fwd_hazard_unit #(.REG_AW(5), .NUM_FWD_STAGES(3), .LOAD_LAT(2)) dut_b (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus_b)
`ifdef STALL_CNT_EN
    ,
    .Stall_count (cnt_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one ID-stage instruction; settles combinational Stall before returning.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic wr, input logic ld);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_uses_rs = urs;
    id_uses_rt = urt;
    id_rdest   = dst;
    id_writes  = wr;
    id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    flush    = 1'b0;
    reset    = 1'b1;
    idle();
    cyc();
    cyc();
    check_val("rst_stall_a", 32'(bus_a.Stall), 32'd0);
    check_val("rst_fwdA_a", 32'(bus_a.EX_fwdA), 32'd0);
    check_val("rst_fwdB_a", 32'(bus_a.EX_fwdB), 32'd0);
    reset = 1'b0;
`ifdef STALL_CNT_EN
    check_val("rst_cnt_a", cnt_a, 32'd0);
`endif

    // 1: add $3,$1,$2 ; add $4,$3,$3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    check_val("t1_stall0", 32'(bus_a.Stall), 32'd0);
    cyc();
    check_val("t1_first_fwdA", 32'(bus_a.EX_fwdA), 32'd0);
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    check_val("t1_stall1", 32'(bus_a.Stall), 32'd0);
    cyc();
    check_val("t1_fwdA", 32'(bus_a.EX_fwdA), 32'd1);
    check_val("t1_fwdB", 32'(bus_a.EX_fwdB), 32'd1);
    idle(); cyc(); cyc();

    // 2: add $3 ; nop ; sub $5,$3,$2
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    check_val("t2_stall", 32'(bus_a.Stall), 32'd0);
    cyc();
    check_val("t2_fwdA", 32'(bus_a.EX_fwdA), 32'd2);
    check_val("t2_fwdB", 32'(bus_a.EX_fwdB), 32'd0);
    idle(); cyc(); cyc();

    // 2b: $3 written in both slots, youngest wins
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc();
    check_val("t2b_fwdA", 32'(bus_a.EX_fwdA), 32'd1);
    check_val("t2b_fwdB", 32'(bus_a.EX_fwdB), 32'd1);
    idle(); cyc(); cyc();

    // 3: lw $3 ; add $4,$3,$1 -> one bubble then MEM/WB forward from stage 2
    drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    check_val("t3_stall_on", 32'(bus_a.Stall), 32'd1);
    cyc();
    check_val("t3_bubble_fwdA", 32'(bus_a.EX_fwdA), 32'd0);
    check_val("t3_bubble_fwdB", 32'(bus_a.EX_fwdB), 32'd0);
    check_val("t3_stall_off", 32'(bus_a.Stall), 32'd0);
    cyc();
    check_val("t3_fwdA", 32'(bus_a.EX_fwdA), 32'd2);
    check_val("t3_fwdB", 32'(bus_a.EX_fwdB), 32'd0);
    idle(); cyc(); cyc();

    // 4a: write to $0 never forwards
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    check_val("t4a_stall", 32'(bus_a.Stall), 32'd0);
    cyc();
    check_val("t4a_fwdA", 32'(bus_a.EX_fwdA), 32'd0);
    check_val("t4a_fwdB", 32'(bus_a.EX_fwdB), 32'd0);
    idle(); cyc(); cyc();

    // 4b: lw $6 then rt=$6 with ID_uses_rt=0 -> no stall, no forward
    drive(1'b1, 5'd1, 5'd6, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd1, 5'd6, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    check_val("t4b_stall", 32'(bus_a.Stall), 32'd0);
    cyc();
    check_val("t4b_fwdB", 32'(bus_a.EX_fwdB), 32'd0);
    idle(); cyc(); cyc();

    // 4c: Flush during load-use stall
    drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    cyc();
    flush = 1'b1;
    drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    check_val("t4c_flush_stall", 32'(bus_a.Stall), 32'd0);
    cyc();
    flush = 1'b0;
    check_val("t4c_bubble_fwdA", 32'(bus_a.EX_fwdA), 32'd0);
    drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    check_val("t4c_killed_stall", 32'(bus_a.Stall), 32'd0);
    cyc();
    check_val("t4c_killed_fwdA", 32'(bus_a.EX_fwdA), 32'd0);
    check_val("t4c_killed_fwdB", 32'(bus_a.EX_fwdB), 32'd0);
    idle(); cyc(); cyc(); cyc();

    // 5: N=3, LOAD_LAT=2: lw $7 ; add $8,$7,$7 -> 2 stalls then sel 3
    drive(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    check_val("t5_stall_c1", 32'(bus_b.Stall), 32'd1);
    cyc();
    check_val("t5_bub1_fwdA", 32'(bus_b.EX_fwdA), 32'd0);
    check_val("t5_stall_c2", 32'(bus_b.Stall), 32'd1);
    cyc();
    check_val("t5_bub2_fwdA", 32'(bus_b.EX_fwdA), 32'd0);
    check_val("t5_stall_c3", 32'(bus_b.Stall), 32'd0);
    cyc();
    check_val("t5_fwdA", 32'(bus_b.EX_fwdA), 32'd3);
    check_val("t5_fwdB", 32'(bus_b.EX_fwdB), 32'd3);
    idle(); cyc(); cyc(); cyc();

    // 6: Reset in the middle of a load-use stall
    drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    check_val("t6_pre_stall", 32'(bus_a.Stall), 32'd1);
    reset = 1'b1;
    #1;
    check_val("t6_stall_in_rst", 32'(bus_a.Stall), 32'd0);
    cyc();
    check_val("t6_fwdA", 32'(bus_a.EX_fwdA), 32'd0);
    check_val("t6_fwdB", 32'(bus_a.EX_fwdB), 32'd0);
`ifdef STALL_CNT_EN
    check_val("t6_cnt", cnt_a, 32'd0);
`endif
    reset = 1'b0;
    #1;
    check_val("t6_stall_after", 32'(bus_a.Stall), 32'd0);
    cyc();
    idle(); cyc(); cyc();

`ifdef STALL_CNT_EN
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
      cyc();
      drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      cyc();
      cyc();
    end
    idle();
    check_val("cnt_five", cnt_a, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
